// File: rtl/se_sram_arbiter_2port.sv
// Two-port byte-request arbiter in front of the 64Kx8 single-port synchronous SRAM.
// Registered SRAM controls, 2-cycle read latency, one access per cycle.
module se_sram_arbiter_2port #(
  parameter bit round_robin = 1'b1
) (
  input  logic        sram_clock,
  input  logic        reset,

  input  logic        a_req_valid,
  output logic        a_req_ready,
  input  logic [15:0] a_req_address,
  input  logic        a_req_read_not_write,
  input  logic [7:0]  a_req_write_data,
  output logic        a_resp_valid,
  output logic [7:0]  a_resp_data,

  input  logic        b_req_valid,
  output logic        b_req_ready,
  input  logic [15:0] b_req_address,
  input  logic        b_req_read_not_write,
  input  logic [7:0]  b_req_write_data,
  output logic        b_resp_valid,
  output logic [7:0]  b_resp_data,

  output logic [15:0] sram_address,
  output logic [7:0]  sram_write_data,
  output logic        sram_select,
  output logic        sram_read_not_write,
  output logic        sram_write_enable,
  input  logic [7:0]  sram_data_out
);

  logic        last_grant_b_q;
  logic        a_wins;
  logic        grant_a;
  logic        grant_b;
  logic        handshake;
  logic [15:0] sel_address;
  logic [7:0]  sel_write_data;
  logic        sel_read;

  // Read tracking: stage 1 = SRAM access cycle, stage 2 = data-out cycle. Tag 1 = port B.
  logic        rd_valid1_q, rd_tag1_q;
  logic        rd_valid2_q, rd_tag2_q;
  logic [7:0]  a_data_q, b_data_q;

  // Grant depends only on the valids and last_grant, never on request payloads.
  always_comb begin
    a_wins         = a_req_valid && (!b_req_valid || !round_robin || last_grant_b_q);
    grant_a        = !reset && a_wins;
    grant_b        = !reset && b_req_valid && !a_wins;
    handshake      = grant_a || grant_b;
    sel_address    = grant_b ? b_req_address        : a_req_address;
    sel_write_data = grant_b ? b_req_write_data     : a_req_write_data;
    sel_read       = grant_b ? b_req_read_not_write : a_req_read_not_write;
  end

  assign a_req_ready = grant_a;
  assign b_req_ready = grant_b;

  always_ff @(posedge sram_clock) begin
    if (reset) begin
      last_grant_b_q      <= 1'b1;
      sram_address        <= 16'h0000;
      sram_write_data     <= 8'h00;
      sram_select         <= 1'b0;
      sram_read_not_write <= 1'b0;
      sram_write_enable   <= 1'b0;
      rd_valid1_q         <= 1'b0;
      rd_tag1_q           <= 1'b0;
      rd_valid2_q         <= 1'b0;
      rd_tag2_q           <= 1'b0;
      a_data_q            <= 8'h00;
      b_data_q            <= 8'h00;
    end else begin
      sram_select <= handshake;
      if (handshake) begin
        last_grant_b_q      <= grant_b;
        sram_address        <= sel_address;
        sram_write_data     <= sel_write_data;
        sram_read_not_write <= sel_read;
        sram_write_enable   <= !sel_read;
      end else begin
        sram_read_not_write <= 1'b0;
        sram_write_enable   <= 1'b0;
      end
      rd_valid1_q <= handshake && sel_read;
      rd_tag1_q   <= grant_b;
      rd_valid2_q <= rd_valid1_q;
      rd_tag2_q   <= rd_tag1_q;
      if (a_resp_valid) a_data_q <= sram_data_out;
      if (b_resp_valid) b_data_q <= sram_data_out;
    end
  end

  assign a_resp_valid = !reset && rd_valid2_q && !rd_tag2_q;
  assign b_resp_valid = !reset && rd_valid2_q && rd_tag2_q;
  assign a_resp_data  = a_resp_valid ? sram_data_out : a_data_q;
  assign b_resp_data  = b_resp_valid ? sram_data_out : b_data_q;

endmodule

// File: tb/tb_se_sram_arbiter_2port.sv
// Directed bench for se_sram_arbiter_2port with a behavioural 64Kx8 SRAM behind it.
// A second instance with fixed priority shares the request inputs for grant checks.
module tb_se_sram_arbiter_2port;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req_valid, a_req_rnw, b_req_valid, b_req_rnw;
  logic [15:0] a_req_address, b_req_address;
  logic [7:0]  a_req_wdata, b_req_wdata;
  logic        a_req_ready, b_req_ready, a_resp_valid, b_resp_valid;
  logic [7:0]  a_resp_data, b_resp_data;
  logic [15:0] sram_address;
  logic [7:0]  sram_write_data, sram_data_out;
  logic        sram_select, sram_read_not_write, sram_write_enable;

  logic        fp_a_ready, fp_b_ready, fp_a_resp_valid, fp_b_resp_valid;
  logic [7:0]  fp_a_resp_data, fp_b_resp_data, fp_wdata;
  logic [15:0] fp_address;
  logic        fp_select, fp_rnw, fp_we;

  int checks = 0;
  int errors = 0;

  bit [7:0] mem [0:65535];

  always #5 clk = ~clk;

  // Behavioural synchronous SRAM: data_out valid the cycle after a selected read.
  always @(posedge clk) begin
    if (sram_select) begin
      if (sram_write_enable) mem[sram_address] <= sram_write_data;
      else if (sram_read_not_write) sram_data_out <= mem[sram_address];
    end
  end

  se_sram_arbiter_2port #(.round_robin(1'b1)) dut (
    .sram_clock          (clk),
    .reset               (reset),
    .a_req_valid         (a_req_valid),
    .a_req_ready         (a_req_ready),
    .a_req_address       (a_req_address),
    .a_req_read_not_write(a_req_rnw),
    .a_req_write_data    (a_req_wdata),
    .a_resp_valid        (a_resp_valid),
    .a_resp_data         (a_resp_data),
    .b_req_valid         (b_req_valid),
    .b_req_ready         (b_req_ready),
    .b_req_address       (b_req_address),
    .b_req_read_not_write(b_req_rnw),
    .b_req_write_data    (b_req_wdata),
    .b_resp_valid        (b_resp_valid),
    .b_resp_data         (b_resp_data),
    .sram_address        (sram_address),
    .sram_write_data     (sram_write_data),
    .sram_select         (sram_select),
    .sram_read_not_write (sram_read_not_write),
    .sram_write_enable   (sram_write_enable),
    .sram_data_out       (sram_data_out)
  );

  se_sram_arbiter_2port #(.round_robin(1'b0)) dut_fp (
    .sram_clock          (clk),
    .reset               (reset),
    .a_req_valid         (a_req_valid),
    .a_req_ready         (fp_a_ready),
    .a_req_address       (a_req_address),
    .a_req_read_not_write(a_req_rnw),
    .a_req_write_data    (a_req_wdata),
    .a_resp_valid        (fp_a_resp_valid),
    .a_resp_data         (fp_a_resp_data),
    .b_req_valid         (b_req_valid),
    .b_req_ready         (fp_b_ready),
    .b_req_address       (b_req_address),
    .b_req_read_not_write(b_req_rnw),
    .b_req_write_data    (b_req_wdata),
    .b_resp_valid        (fp_b_resp_valid),
    .b_resp_data         (fp_b_resp_data),
    .sram_address        (fp_address),
    .sram_write_data     (fp_wdata),
    .sram_select         (fp_select),
    .sram_read_not_write (fp_rnw),
    .sram_write_enable   (fp_we),
    .sram_data_out       (8'h00)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
  endtask

  task automatic drive_a(input logic rnw, input logic [15:0] addr, input logic [7:0] data);
    a_req_valid = 1'b1; a_req_rnw = rnw; a_req_address = addr; a_req_wdata = data;
  endtask

  task automatic drive_b(input logic rnw, input logic [15:0] addr, input logic [7:0] data);
    b_req_valid = 1'b1; b_req_rnw = rnw; b_req_address = addr; b_req_wdata = data;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    a_req_rnw = 1'b1; b_req_rnw = 1'b1;
    a_req_address = 16'h0; b_req_address = 16'h0;
    a_req_wdata = 8'h0; b_req_wdata = 8'h0;
    #1;
    step();
    // Ready suppressed while reset is high
    drive_a(1'b1, 16'h0010, 8'h00);
    drive_b(1'b1, 16'h0020, 8'h00);
    #1;
    check_eq("rst_a_ready", a_req_ready, 0);
    check_eq("rst_b_ready", b_req_ready, 0);
    step();
    reset = 1'b0;
    idle_inputs();
    #1;
    check_eq("rst_select", sram_select, 0);
    check_eq("rst_we", sram_write_enable, 0);
    check_eq("rst_rnw", sram_read_not_write, 0);
    check_eq("rst_addr", sram_address, 16'h0000);
    check_eq("rst_wdata", sram_write_data, 8'h00);
    check_eq("rst_a_resp_valid", a_resp_valid, 0);
    check_eq("rst_b_resp_valid", b_resp_valid, 0);
    check_eq("rst_a_resp_data", a_resp_data, 8'h00);
    check_eq("rst_b_resp_data", b_resp_data, 8'h00);

    // A writes 0x5A to 0x1234
    drive_a(1'b0, 16'h1234, 8'h5A);
    #1;
    check_eq("wr_a_ready", a_req_ready, 1);
    check_eq("wr_b_ready", b_req_ready, 0);
    step();
    idle_inputs();
    check_eq("wr_select", sram_select, 1);
    check_eq("wr_we", sram_write_enable, 1);
    check_eq("wr_rnw", sram_read_not_write, 0);
    check_eq("wr_addr", sram_address, 16'h1234);
    check_eq("wr_wdata", sram_write_data, 8'h5A);
    check_eq("wr_a_resp", a_resp_valid, 0);
    check_eq("wr_b_resp", b_resp_valid, 0);
    step();
    check_eq("wr_select_n2", sram_select, 0);
    check_eq("wr_we_n2", sram_write_enable, 0);
    check_eq("wr_a_resp_n2", a_resp_valid, 0);

    // A reads 0x1234
    drive_a(1'b1, 16'h1234, 8'h00);
    step();
    idle_inputs();
    check_eq("rd_select", sram_select, 1);
    check_eq("rd_rnw", sram_read_not_write, 1);
    check_eq("rd_we", sram_write_enable, 0);
    check_eq("rd_a_resp_m1", a_resp_valid, 0);
    step();
    check_eq("rd_a_resp_valid", a_resp_valid, 1);
    check_eq("rd_a_resp_data", a_resp_data, 8'h5A);
    check_eq("rd_b_resp_valid", b_resp_valid, 0);
    step();
    check_eq("rd_a_resp_m3", a_resp_valid, 0);

    // Preload distinct data for the contention reads
    drive_a(1'b0, 16'h0001, 8'h11);
    step();
    idle_inputs();
    drive_b(1'b0, 16'h0002, 8'h22);
    step();
    idle_inputs();
    step();
    pulse_reset();

    // Contention: both read for 4 cycles; RR grants A,B,A,B, fixed priority grants A
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        drive_a(1'b1, 16'h0001, 8'h00);
        drive_b(1'b1, 16'h0002, 8'h00);
      end else begin
        idle_inputs();
      end
      #1;
      if (c < 4) begin
        check_eq($sformatf("rr_a_ready_%0d", c), a_req_ready, (c % 2 == 0) ? 1 : 0);
        check_eq($sformatf("rr_b_ready_%0d", c), b_req_ready, (c % 2 == 1) ? 1 : 0);
        check_eq($sformatf("fp_a_ready_%0d", c), fp_a_ready, 1);
        check_eq($sformatf("fp_b_ready_%0d", c), fp_b_ready, 0);
      end
      check_eq($sformatf("rr_a_resp_%0d", c), a_resp_valid, (c >= 2 && c % 2 == 0) ? 1 : 0);
      check_eq($sformatf("rr_b_resp_%0d", c), b_resp_valid, (c >= 2 && c % 2 == 1) ? 1 : 0);
      if (c >= 2 && c % 2 == 0) check_eq($sformatf("rr_a_data_%0d", c), a_resp_data, 8'h11);
      if (c >= 2 && c % 2 == 1) check_eq($sformatf("rr_b_data_%0d", c), b_resp_data, 8'h22);
      step();
    end
    idle_inputs();

    // Write-then-read hazard at 0xFFFF
    drive_b(1'b0, 16'hFFFF, 8'hC3);
    step();
    idle_inputs();
    drive_a(1'b1, 16'hFFFF, 8'h00);
    #1;
    check_eq("hz_a_ready", a_req_ready, 1);
    step();
    idle_inputs();
    check_eq("hz_addr", sram_address, 16'hFFFF);
    step();
    check_eq("hz_a_resp_valid", a_resp_valid, 1);
    check_eq("hz_a_resp_data", a_resp_data, 8'hC3);
    check_eq("hz_b_resp_valid", b_resp_valid, 0);

    // Read-then-write at 0xFFFE returns the old value
    drive_a(1'b1, 16'hFFFE, 8'h00);
    step();
    idle_inputs();
    drive_b(1'b0, 16'hFFFE, 8'h77);
    step();
    idle_inputs();
    check_eq("rw_a_resp_valid", a_resp_valid, 1);
    check_eq("rw_a_resp_data", a_resp_data, 8'h00);

    // Idle for 3 cycles
    step();
    step();
    step();
    check_eq("idle_select", sram_select, 0);
    check_eq("idle_we", sram_write_enable, 0);
    check_eq("idle_rnw", sram_read_not_write, 0);
    check_eq("idle_addr", sram_address, 16'hFFFE);
    check_eq("idle_a_resp", a_resp_valid, 0);
    check_eq("idle_b_resp", b_resp_valid, 0);

    // Reset mid-read; last grant is A before reset
    drive_a(1'b1, 16'h1234, 8'h00);
    step();
    idle_inputs();
    reset = 1'b1;
    #1;
    check_eq("mr_a_resp_rst", a_resp_valid, 0);
    step();
    reset = 1'b0;
    #1;
    check_eq("mr_select", sram_select, 0);
    check_eq("mr_a_resp_n2", a_resp_valid, 0);
    step();
    check_eq("mr_a_resp_n3", a_resp_valid, 0);
    drive_a(1'b1, 16'h0001, 8'h00);
    drive_b(1'b1, 16'h0002, 8'h00);
    #1;
    check_eq("mr_a_wins", a_req_ready, 1);
    check_eq("mr_b_ready", b_req_ready, 0);
    step();
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
